// File: rtl/hps_pio_pkg.sv
// Shared constants for the HPS PIO edge-capture block: register map and edge modes.
package hps_pio_pkg;

  localparam int unsigned BUS_W  = 32;
  localparam int unsigned ADDR_W = 2;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_RSVD = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned MAX_WIDTH       = 32;
  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES = 3;

endpackage

// File: rtl/hps_pio_sync.sv
// Multi-flop synchronizer for a vector of asynchronous inputs.
module hps_pio_sync
  import hps_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/hps_pio_edge_capture.sv
// PIO input port with synchronizer, sticky write-1-to-clear edge capture,
// interrupt mask and a registered level interrupt.
module hps_pio_edge_capture
  import hps_pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write,
  input  logic [BUS_W-1:0]  writedata,
  input  logic [WIDTH-1:0]  in_port,
  output logic [BUS_W-1:0]  readdata,
  output logic              irq
);

  // Reject illegal configurations at elaboration time.
  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("hps_pio_edge_capture: WIDTH must be 1..32");
  end
  if (EDGE_TYPE > EDGE_ANY) begin : g_bad_edge
    $error("hps_pio_edge_capture: EDGE_TYPE must be 0, 1 or 2");
  end
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_sync
    $error("hps_pio_edge_capture: SYNC_STAGES must be 2..3");
  end

  logic [WIDTH-1:0] data_sync;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;

  logic [WIDTH-1:0] edge_det_c;
  logic [WIDTH-1:0] clr_c;
  logic             wr_en_c;
  logic [BUS_W-1:0] rd_next_c;
  logic             unused_wdata_c;

  hps_pio_sync #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset_n(reset_n),
    .d      (in_port),
    .q      (data_sync)
  );

  // Per-bit edge detector selected by EDGE_TYPE.
  always_comb begin
    edge_det_c = '0;
    if (EDGE_TYPE == EDGE_FALLING)  edge_det_c = ~data_sync & prev;
    else if (EDGE_TYPE == EDGE_ANY) edge_det_c = data_sync ^ prev;
    else                            edge_det_c = data_sync & ~prev;
  end

  assign wr_en_c        = chipselect & write;
  assign clr_c          = (wr_en_c && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata_c = ^writedata;

  // Read mux; upper bus bits are zero by the width cast.
  always_comb begin
    rd_next_c = '0;
    case (address)
      ADDR_DATA: rd_next_c = BUS_W'(data_sync);
      ADDR_RSVD: rd_next_c = '0;
      ADDR_MASK: rd_next_c = BUS_W'(irq_mask);
      ADDR_EDGE: rd_next_c = BUS_W'(edge_capture);
      default:   rd_next_c = '0;
    endcase
  end

  // Set has priority over a same-cycle write-1-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev         <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      irq          <= 1'b0;
      readdata     <= '0;
    end else begin
      prev         <= data_sync;
      edge_capture <= (edge_capture & ~clr_c) | edge_det_c;
      irq          <= |(edge_capture & irq_mask);
      readdata     <= rd_next_c;
      if (wr_en_c && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_hps_pio_edge_capture.sv
// Directed scoreboard bench: three instances (rising, falling, any edge) share one bus and input.
module tb_hps_pio_edge_capture;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd1, rd2;
  logic        irq0, irq1, irq2;

  typedef struct {
    string       tag;
    int          dut;
    bit          is_irq;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int total = 0;
  int bad   = 0;

  hps_pio_edge_capture #(.WIDTH(8), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));

  hps_pio_edge_capture #(.WIDTH(8), .EDGE_TYPE(1), .SYNC_STAGES(2)) dut_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));

  hps_pio_edge_capture #(.WIDTH(8), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write(write), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish, obs=running exp=done");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic exp_rd(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2);
    sb_q.push_back('{tag, 0, 1'b0, e0});
    sb_q.push_back('{tag, 1, 1'b0, e1});
    sb_q.push_back('{tag, 2, 1'b0, e2});
  endtask

  task automatic exp_irq(input string tag, input logic e0, input logic e1, input logic e2);
    sb_q.push_back('{tag, 0, 1'b1, {31'b0, e0}});
    sb_q.push_back('{tag, 1, 1'b1, {31'b0, e1}});
    sb_q.push_back('{tag, 2, 1'b1, {31'b0, e2}});
  endtask

  function automatic logic [31:0] observe(input int dut, input bit is_irq);
    logic [31:0] rd;
    logic        iq;
    case (dut)
      0:       begin rd = rd0; iq = irq0; end
      1:       begin rd = rd1; iq = irq1; end
      default: begin rd = rd2; iq = irq2; end
    endcase
    return is_irq ? {31'b0, iq} : rd;
  endfunction

  // Pop every pending expectation and compare against the outputs now.
  task automatic check_all();
    sb_entry_t   e;
    logic [31:0] obs;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      obs = observe(e.dut, e.is_irq);
      total++;
      assert (obs === e.exp) else begin
        bad++;
        $error("FAIL %s dut%0d %s obs=%h exp=%h", e.tag, e.dut,
               e.is_irq ? "irq" : "readdata", obs, e.exp);
      end
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write = 1'b1; writedata = d;
    tick(1);
    chipselect = 1'b0; write = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0;
    address = 2'd0; writedata = '0; in_port = 8'h00;

    tick(3);
    exp_rd("reset_rd", 0, 0, 0);
    exp_irq("reset_irq", 0, 0, 0);
    check_all();
    reset_n = 1'b1;
    tick(3);

    bus_write(2'd2, 32'h0000_0004);
    tick(1);
    exp_rd("mask_rd", 32'h4, 32'h4, 32'h4);
    check_all();

    // Input change and its latency through synchronizer and capture.
    address = 2'd0; in_port = 8'h05;
    exp_rd("data_early", 0, 0, 0);
    tick(2);
    check_all();
    exp_rd("data_edge3", 32'h5, 32'h5, 32'h5);
    exp_irq("irq_edge3", 0, 0, 0);
    tick(1);
    check_all();
    address = 2'd3;
    exp_rd("cap_rise", 32'h5, 32'h0, 32'h5);
    exp_irq("irq_edge4", 1, 0, 1);
    tick(1);
    check_all();

    // W1C bit 2: irq drops one cycle after the clear lands.
    exp_rd("w1c_old", 32'h5, 32'h0, 32'h5);
    exp_irq("irq_hold", 1, 0, 1);
    bus_write(2'd3, 32'h0000_0004);
    check_all();
    exp_rd("w1c_new", 32'h1, 32'h0, 32'h1);
    exp_irq("irq_drop", 0, 0, 0);
    tick(1);
    check_all();

    // Falling edge on bit 0, then a rising edge colliding with a W1C of bit 0.
    in_port = 8'h04;
    exp_rd("fall_b0", 32'h1, 32'h1, 32'h1);
    tick(4);
    check_all();
    in_port = 8'h05;
    tick(2);
    bus_write(2'd3, 32'h0000_0001);
    exp_rd("set_wins", 32'h1, 32'h0, 32'h1);
    tick(1);
    check_all();

    // Pulse bit 3 with the mask cleared.
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h0000_00FF);
    exp_rd("clear_all", 0, 0, 0);
    exp_irq("irq_masked0", 0, 0, 0);
    tick(1);
    check_all();
    in_port = 8'h0D;
    exp_rd("pulse_rise", 32'h8, 32'h0, 32'h8);
    exp_irq("irq_masked1", 0, 0, 0);
    tick(4);
    check_all();
    in_port = 8'h05;
    exp_rd("pulse_fall", 32'h8, 32'h8, 32'h8);
    exp_irq("irq_masked2", 0, 0, 0);
    tick(4);
    check_all();

    // Writes to data/reserved are ignored; upper read bits stay zero.
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    exp_rd("rsvd_rd", 0, 0, 0);
    tick(1);
    check_all();
    address = 2'd0;
    exp_rd("data_rd", 32'h5, 32'h5, 32'h5);
    tick(1);
    check_all();
    address = 2'd2;
    exp_rd("mask_kept", 0, 0, 0);
    tick(1);
    check_all();
    address = 2'd3;
    exp_rd("cap_kept", 32'h8, 32'h8, 32'h8);
    tick(1);
    check_all();
    bus_write(2'd2, 32'hFFFF_FFFF);
    exp_rd("mask_zext", 32'hFF, 32'hFF, 32'hFF);
    exp_irq("irq_unmask", 1, 1, 1);
    tick(1);
    check_all();

    // Asynchronous reset in the middle of a mask write.
    address = 2'd2; chipselect = 1'b1; write = 1'b1; writedata = 32'h33;
    #2 reset_n = 1'b0;
    #1;
    exp_rd("async_rd", 0, 0, 0);
    exp_irq("async_irq", 0, 0, 0);
    check_all();
    tick(1);
    chipselect = 1'b0; write = 1'b0; reset_n = 1'b1;
    exp_rd("wr_dropped", 0, 0, 0);
    tick(1);
    check_all();

    // Input already high at release is captured as a rising edge.
    address = 2'd3;
    exp_rd("post_rst_early", 0, 0, 0);
    tick(1);
    check_all();
    exp_rd("post_rst_cap", 32'h5, 32'h0, 32'h5);
    exp_irq("post_rst_irq", 0, 0, 0);
    tick(2);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
